// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: run enable and colour into the generator, counters, syncs and colour out.
interface vga_timing_gen_if #(
  parameter int CW = 8,
  parameter int XW = 10,
  parameter int YW = 10
);
  logic            en;
  logic [3*CW-1:0] pixel_in;
  logic [XW-1:0]   pixel_num;
  logic [YW-1:0]   linea_num;
  logic            pixel_tick;
  logic [3*CW-1:0] pixel_out;
  logic            hsync;
  logic            vsync;
  logic            n_blank;
  logic            frame_start;

  modport master (
    input  en, pixel_in,
    output pixel_num, linea_num, pixel_tick, pixel_out,
    output hsync, vsync, n_blank, frame_start
  );

  modport slave (
    output en, pixel_in,
    input  pixel_num, linea_num, pixel_tick, pixel_out,
    input  hsync, vsync, n_blank, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: clock divider, pixel/line counters, and a one-tick-delayed
// registered stage carrying syncs, blanking, colour and the frame-start pulse.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int CW       = 8,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input logic             clk,
  input logic             rst,
  vga_timing_gen_if.master bus
);

  localparam int H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [XW-1:0]    H_LAST   = XW'(H_TOT - 1);
  localparam logic [YW-1:0]    V_LAST   = YW'(V_TOT - 1);

  // One extra bit so region bounds equal to 2**XW / 2**YW still compare correctly.
  localparam logic [XW:0] H_ACT_C  = (XW+1)'(H_ACTIVE);
  localparam logic [XW:0] HS_BEG_C = (XW+1)'(H_ACTIVE + H_FRONT);
  localparam logic [XW:0] HS_END_C = (XW+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [YW:0] V_ACT_C  = (YW+1)'(V_ACTIVE);
  localparam logic [YW:0] VS_BEG_C = (YW+1)'(V_ACTIVE + V_FRONT);
  localparam logic [YW:0] VS_END_C = (YW+1)'(V_ACTIVE + V_FRONT + V_SYNC);

  function automatic logic h_active(input logic [XW-1:0] x);
    return {1'b0, x} < H_ACT_C;
  endfunction

  function automatic logic h_sync(input logic [XW-1:0] x);
    return ({1'b0, x} >= HS_BEG_C) && ({1'b0, x} < HS_END_C);
  endfunction

  function automatic logic v_active(input logic [YW-1:0] y);
    return {1'b0, y} < V_ACT_C;
  endfunction

  function automatic logic v_sync(input logic [YW-1:0] y);
    return ({1'b0, y} >= VS_BEG_C) && ({1'b0, y} < VS_END_C);
  endfunction

  logic [DIV_W-1:0] div_p0;
  logic [XW-1:0]    x_p0;
  logic [YW-1:0]    y_p0;
  logic             vld_p0;

  logic             hsync_p1;
  logic             vsync_p1;
  logic             nblank_p1;
  logic [3*CW-1:0]  pixel_p1;
  logic             fs_p1;

  // Stage p0: divider and raster counters; vld_p0 is the pixel tick.
  always_comb vld_p0 = bus.en & ~rst & (div_p0 == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_p0 <= '0;
    end else if (bus.en) begin
      div_p0 <= (div_p0 == DIV_LAST) ? '0 : div_p0 + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_p0 <= '0;
      y_p0 <= '0;
    end else if (vld_p0) begin
      if (x_p0 == H_LAST) begin
        x_p0 <= '0;
        y_p0 <= (y_p0 == V_LAST) ? '0 : y_p0 + 1'b1;
      end else begin
        x_p0 <= x_p0 + 1'b1;
      end
    end
  end

  // Stage p1: decode of the p0 coordinate, loaded only on a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_p1  <= ~HS_POL;
      vsync_p1  <= ~VS_POL;
      nblank_p1 <= 1'b0;
      pixel_p1  <= '0;
      fs_p1     <= 1'b0;
    end else begin
      fs_p1 <= vld_p0 && (x_p0 == '0) && (y_p0 == '0);
      if (vld_p0) begin
        hsync_p1  <= h_sync(x_p0) ? HS_POL : ~HS_POL;
        vsync_p1  <= v_sync(y_p0) ? VS_POL : ~VS_POL;
        nblank_p1 <= h_active(x_p0) && v_active(y_p0);
        pixel_p1  <= (h_active(x_p0) && v_active(y_p0)) ? bus.pixel_in : '0;
      end
    end
  end

  assign bus.pixel_num   = x_p0;
  assign bus.linea_num   = y_p0;
  assign bus.pixel_tick  = vld_p0;
  assign bus.pixel_out   = pixel_p1;
  assign bus.hsync       = hsync_p1;
  assign bus.vsync       = vsync_p1;
  assign bus.n_blank     = nblank_p1;
  assign bus.frame_start = fs_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: a default-geometry instance for horizontal timing, freeze and async reset,
// and a tiny 7x6 instance walked through a full frame from a vector table.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(8), .XW(10), .YW(10)) if_a ();
  vga_timing_gen_if #(.CW(8), .XW(3),  .YW(3))  if_b ();

  assign if_a.pixel_in = {if_a.pixel_num[7:0], if_a.linea_num[7:0], 8'hA5};
  assign if_b.pixel_in = {5'd0, if_b.pixel_num, 5'd0, if_b.linea_num, 8'hA5};

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_ACTIVE(480), .V_FRONT(10), .V_SYNC(2),  .V_BACK(33),
    .HS_POL(1'b0),  .VS_POL(1'b0), .CLK_DIV(2), .CW(8), .XW(10), .YW(10)
  ) dut_a (
    .clk(clk),
    .rst(rst_a),
    .bus(if_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CW(8), .XW(3), .YW(3)
  ) dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(if_b)
  );

  typedef struct {
    int clks;
    bit en;
    int pn;
    int ln;
    int rx;
    int ry;
    bit hs;
    bit vs;
    bit nb;
    bit fs;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pix_a(input int x, input int y);
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    if (x < 640 && y < 480) return {xv[7:0], yv[7:0], 8'hA5};
    return 24'h0;
  endfunction

  task automatic chk_a_reset(input string tag);
    chk({tag, "_pn"},   if_a.pixel_num, 0);
    chk({tag, "_ln"},   if_a.linea_num, 0);
    chk({tag, "_tick"}, if_a.pixel_tick, 0);
    chk({tag, "_pout"}, if_a.pixel_out, 0);
    chk({tag, "_nb"},   if_a.n_blank, 0);
    chk({tag, "_hs"},   if_a.hsync, 1);
    chk({tag, "_vs"},   if_a.vsync, 1);
    chk({tag, "_fs"},   if_a.frame_start, 0);
  endtask

  initial begin
    int hs_low;
    int frozen_bad;
    logic [9:0]  s_pn;
    logic [9:0]  s_ln;
    logic [23:0] s_pout;
    logic        s_hs, s_vs, s_nb;

    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.en = 1'b0;
    if_b.en = 1'b1;
    step();
    step();
    if_a.en = 1'b1;
    step();
    chk_a_reset("a_rst");

    // Line 0 and the start of line 1 at default geometry.
    rst_a = 1'b0;
    #1;
    chk("a_tick_after_release", if_a.pixel_tick, 0);
    hs_low = 0;
    for (int t = 1; t <= 820; t++) begin
      int idx, rx, ry;
      step();
      chk("a_tick_odd", if_a.pixel_tick, 1);
      step();
      chk("a_tick_even", if_a.pixel_tick, 0);
      idx = t - 1;
      rx = idx % 800;
      ry = idx / 800;
      chk("a_pn",   if_a.pixel_num, t % 800);
      chk("a_ln",   if_a.linea_num, t / 800);
      chk("a_hs",   if_a.hsync, (rx >= 656 && rx < 752) ? 0 : 1);
      chk("a_vs",   if_a.vsync, 1);
      chk("a_nb",   if_a.n_blank, (rx < 640 && ry < 480) ? 1 : 0);
      chk("a_pout", if_a.pixel_out, pix_a(rx, ry));
      chk("a_fs",   if_a.frame_start, (idx == 0) ? 1 : 0);
      if (ry == 0 && if_a.hsync == 1'b0) hs_low++;
    end
    chk("a_hsync_low_ticks", hs_low, 96);

    // Freeze mid-line for 37 clocks, then resume.
    if_a.en = 1'b0;
    s_pn   = if_a.pixel_num;
    s_ln   = if_a.linea_num;
    s_pout = if_a.pixel_out;
    s_hs   = if_a.hsync;
    s_vs   = if_a.vsync;
    s_nb   = if_a.n_blank;
    chk("a_freeze_start_pn", s_pn, 20);
    frozen_bad = 0;
    repeat (37) begin
      step();
      if (if_a.pixel_num !== s_pn || if_a.linea_num !== s_ln || if_a.pixel_out !== s_pout ||
          if_a.hsync !== s_hs || if_a.vsync !== s_vs || if_a.n_blank !== s_nb ||
          if_a.pixel_tick !== 1'b0 || if_a.frame_start !== 1'b0)
        frozen_bad++;
    end
    chk("a_frozen_changes", frozen_bad, 0);
    if_a.en = 1'b1;
    step();
    chk("a_resume_hold_pn", if_a.pixel_num, 20);
    chk("a_resume_tick", if_a.pixel_tick, 1);
    step();
    chk("a_resume_pn", if_a.pixel_num, 21);
    chk("a_resume_ln", if_a.linea_num, 1);
    chk("a_resume_pout", if_a.pixel_out, pix_a(20, 1));
    chk("a_resume_nb", if_a.n_blank, 1);

    // Asynchronous reset at pixel 300, between clock edges.
    repeat (558) step();
    chk("a_pre_rst_pn", if_a.pixel_num, 300);
    chk("a_pre_rst_pout", if_a.pixel_out, pix_a(299, 1));
    #3;
    rst_a = 1'b1;
    #1;
    chk_a_reset("a_async");
    step();
    rst_a = 1'b0;
    step();
    chk("a_rel_tick", if_a.pixel_tick, 1);
    chk("a_rel_pn0", if_a.pixel_num, 0);
    chk("a_rel_fs0", if_a.frame_start, 0);
    step();
    chk("a_rel_pn1", if_a.pixel_num, 1);
    chk("a_rel_fs1", if_a.frame_start, 1);
    chk("a_rel_nb", if_a.n_blank, 1);
    chk("a_rel_pout", if_a.pixel_out, pix_a(0, 0));
    step();
    chk("a_rel_fs_drop", if_a.frame_start, 0);

    // Tiny geometry: reset values with active-high syncs, then the vector table.
    chk("b_rst_hs",   if_b.hsync, 0);
    chk("b_rst_vs",   if_b.vsync, 0);
    chk("b_rst_nb",   if_b.n_blank, 0);
    chk("b_rst_pout", if_b.pixel_out, 0);
    chk("b_rst_tick", if_b.pixel_tick, 0);
    chk("b_rst_fs",   if_b.frame_start, 0);
    rst_b = 1'b0;
    #1;
    chk("b_tick_after_release", if_b.pixel_tick, 1);

    tbl[0]  = '{1,  1'b1, 1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{1,  1'b1, 2, 0, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{4,  1'b1, 6, 0, 5, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1,  1'b1, 0, 1, 6, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1,  1'b1, 1, 1, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{5,  1'b0, 1, 1, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{13, 1'b1, 0, 3, 6, 2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1,  1'b1, 1, 3, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{7,  1'b1, 1, 4, 0, 4, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{5,  1'b1, 6, 4, 5, 4, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1,  1'b1, 0, 5, 6, 4, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1,  1'b1, 1, 5, 0, 5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{6,  1'b1, 0, 0, 6, 5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1,  1'b1, 1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1,  1'b1, 2, 0, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 15; i++) begin
      logic [31:0] exp_pout;
      if_b.en = tbl[i].en;
      repeat (tbl[i].clks) step();
      exp_pout = tbl[i].nb ? ((tbl[i].rx << 16) | (tbl[i].ry << 8) | 32'hA5) : 32'h0;
      chk($sformatf("b%0d_pn", i),   if_b.pixel_num, tbl[i].pn);
      chk($sformatf("b%0d_ln", i),   if_b.linea_num, tbl[i].ln);
      chk($sformatf("b%0d_hs", i),   if_b.hsync, tbl[i].hs);
      chk($sformatf("b%0d_vs", i),   if_b.vsync, tbl[i].vs);
      chk($sformatf("b%0d_nb", i),   if_b.n_blank, tbl[i].nb);
      chk($sformatf("b%0d_fs", i),   if_b.frame_start, tbl[i].fs);
      chk($sformatf("b%0d_tick", i), if_b.pixel_tick, tbl[i].en);
      chk($sformatf("b%0d_pout", i), if_b.pixel_out, exp_pout);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Parameters
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- H_ACTIVE, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical porches and sync, in lines.
- HS_POL, 0 / VS_POL, 0: sync asserted level.
- CLK_DIV, 2: clk cycles per pixel, >=1.
- CW, 8: bits per colour channel.
- XW, 10 / YW, 10: coordinate widths, each >= clog2 of the respective total.

Interface
REQ-002 SHALL have ports, one per line: name, direction, width, meaning. Clock and reset come first.
- clk, in, 1: single system clock; all logic on rising edge.
- rst, in, 1: asynchronous, active-high reset.
- en, in, 1: run enable; 0 freezes all counters and outputs.
- pixel_in, in, 3*CW: {R,G,B} for the coordinate presented on pixel_num/linea_num, valid in the same pixel tick.
- pixel_num, out, XW: current horizontal count.
- linea_num, out, YW: current vertical count.
- pixel_tick, out, 1: one-clk pulse marking each pixel advance.
- pixel_out, out, 3*CW: registered colour; zero when blanked.
- hsync, out, 1: registered horizontal sync.
- vsync, out, 1: registered vertical sync.
- n_blank, out, 1: registered; 1 in the active area.
- frame_start, out, 1: one-clk pulse aligned with the first visible pixel output.

Function
REQ-003 SHALL define H_TOT = H_ACTIVE+H_FRONT+H_SYNC+H_BACK and V_TOT = V_ACTIVE+V_FRONT+V_SYNC+V_BACK.
REQ-004 SHALL include a divider counter 0..CLK_DIV-1 that advances when en=1; pixel_tick=1 in the clk where the divider equals CLK_DIV-1.
- CLK_DIV=1: pixel_tick=en every clk.
REQ-005 SHALL, on pixel_tick, advance pixel_num as follows:
- increment by 1;
- at H_TOT-1, wrap to 0 and advance linea_num;
- linea_num wraps from V_TOT-1 to 0.
REQ-006 SHALL hold the divider, pixel_num and linea_num when en=0, resuming exactly where they stopped.
REQ-007 SHALL decode the horizontal regions:
- active: pixel_num < H_ACTIVE;
- hsync asserted: H_ACTIVE+H_FRONT <= pixel_num < H_ACTIVE+H_FRONT+H_SYNC.
REQ-008 SHALL decode the vertical regions:
- active: linea_num < V_ACTIVE;
- vsync asserted: V_ACTIVE+V_FRONT <= linea_num < V_ACTIVE+V_FRONT+V_SYNC.
REQ-009 SHALL drive asserted sync as HS_POL/VS_POL and deasserted sync as the inverse.
REQ-010 SHALL register the decode and pixel_in on pixel_tick, so hsync, vsync, n_blank and pixel_out lag pixel_num/linea_num by exactly one pixel tick and are mutually aligned.
REQ-011 SHALL load pixel_out with pixel_in when active, else with all zeros.
REQ-012 SHALL pulse frame_start for one clk when the registered outputs present coordinate (0,0).
REQ-013 SHALL keep all registered outputs unchanged between pixel ticks.
REQ-014 SHALL use only unsigned arithmetic and compare against elaborated constants; counters never exceed H_TOT-1 / V_TOT-1.

Reset
REQ-015 SHALL, on rst=1 (asynchronous, any time, including mid-line or mid-frame), force:
- divider, pixel_num and linea_num to 0;
- pixel_out to 0, n_blank to 0, pixel_tick to 0, frame_start to 0;
- hsync to ~HS_POL and vsync to ~VS_POL.
REQ-016 SHALL produce the first pixel_tick CLK_DIV clks after rst deassertion with en=1.
- That tick registers coordinate (0,0), so frame_start pulses on that tick.

Verification
REQ-017 Default parameters, en=1, run 2 frames:
- pixel_tick every 2nd clk;
- pixel_num 0..799, linea_num 0..524;
- 420000 ticks per frame.
REQ-018 Sync windows at defaults:
- hsync=0 exactly for registered pixel 656..751 (96 ticks);
- vsync=0 exactly for registered lines 490..491;
- n_blank=1 for 640x480 positions only.
REQ-019 pixel_in = {R=pixel_num[7:0], G=linea_num[7:0], B=8'hA5}:
- pixel_out one tick later equals that value for the active coordinate;
- pixel_out=0 at pixel 640 and at line 480.
REQ-020 rst pulsed at pixel 300, line 200:
- all outputs take their reset values immediately, asynchronously;
- after release, frame_start occurs on the first tick.
REQ-021 en=0 for 37 clks mid-line:
- counters and outputs frozen;
- resume with no skipped or repeated coordinate.
REQ-022 CLK_DIV=1, HS_POL=1, VS_POL=1, 4x3 active with all porches/syncs=1 (H_TOT=7, V_TOT=6):
- hsync=1 only at registered pixel 5;
- vsync=1 only at registered line 4;
- wrap verified.
